// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder, combined in pairs to form the serial full-add stage.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: captures a/b, adds one bit per cycle LSB-first,
// then holds sum/carry_out with a valid/ready handshake until consumed.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int unsigned   CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic ha0_s, ha0_c, ha1_c, sum_bit, carry_bit;

    half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]),  .s(ha0_s),   .c(ha0_c));
    half_adder u_ha1 (.a(ha0_s),  .b(carry_q), .s(sum_bit), .c(ha1_c));
    assign carry_bit = ha0_c | ha1_c;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = 1'b0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            SHIFT: begin
                // Once all WIDTH bits are shifted, one more cycle commits the working
                // result to sum/carry_out, which keep the previous result until then.
                if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    sum_d       = res_q;
                    carry_out_d = carry_q;
                end else begin
                    res_d   = {sum_bit, res_q[WIDTH-1:1]};
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    carry_d = carry_bit;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       carry_out;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, compared=%0d mismatched=%0d", compared, mismatched);
        $fatal(1);
    end

    task automatic accept(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit rnd, output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        compared++;
        if ({in_ready, out_valid, busy, sum, carry_out} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b sum=%h c=%b, want 1 0 0 00 0",
                     in_ready, out_valid, busy, sum, carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int n;
        accept(8'h00, 8'h00);
        wait_valid(1'b0, n);
        compared++;
        if (n !== 9 || out_valid !== 1'b1 || sum !== 8'h00 || carry_out !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_add: got lat=%0d vld=%b sum=%h c=%b, want 9 1 00 0", n, out_valid, sum, carry_out);
        end
        consume();
    endtask

    task automatic test_carry();
        int n;
        accept(8'hFF, 8'h01);
        a = 8'h3C; b = 8'hC3;
        compared++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL carry_shift_flags: got busy=%b rdy=%b, want 1 0", busy, in_ready);
        end
        wait_valid(1'b0, n);
        compared++;
        if (n !== 9 || sum !== 8'h00 || carry_out !== 1'b1) begin
            mismatched++;
            $display("FAIL carry_add: got lat=%0d sum=%h c=%b, want 9 00 1", n, sum, carry_out);
        end
        consume();
    endtask

    task automatic test_hold();
        int n;
        accept(8'hA5, 8'h5A);
        wait_valid(1'b0, n);
        compared++;
        if (n !== 9 || sum !== 8'hFF || carry_out !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_result: got lat=%0d sum=%h c=%b, want 9 ff 0", n, sum, carry_out);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'h11; b = 8'h22;
            @(posedge clk); #1;
            compared++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'hFF || carry_out !== 1'b0) begin
                mismatched++;
                $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b sum=%h c=%b, want 1 0 ff 0",
                         i, out_valid, in_ready, sum, carry_out);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_release: got vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_abort();
        int  n;
        bit  seen = 1'b0;
        accept(8'h80, 8'h80);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({in_ready, out_valid, busy, sum, carry_out} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            mismatched++;
            $display("FAIL abort_reset: got rdy=%b vld=%b busy=%b sum=%h c=%b, want 1 0 0 00 0",
                     in_ready, out_valid, busy, sum, carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        compared++;
        if (seen) begin
            mismatched++;
            $display("FAIL abort_no_result: got out_valid seen=1, want 0");
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; a = 8'h80; b = 8'h80;
        @(posedge clk); #1;
        in_valid = 1'b0;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL first_edge_accept: got busy=%b, want 1", busy);
        end
        wait_valid(1'b0, n);
        compared++;
        if (n !== 9 || sum !== 8'h00 || carry_out !== 1'b1) begin
            mismatched++;
            $display("FAIL after_abort_add: got lat=%0d sum=%h c=%b, want 9 00 1", n, sum, carry_out);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int n;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; a = 8'h0F; b = 8'h01;
        @(posedge clk); #1;
        a = 8'hF0; b = 8'h10;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        compared++;
        if (n !== 9 || sum !== 8'h10 || carry_out !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_first: got lat=%0d sum=%h c=%b, want 9 10 0", n, sum, carry_out);
        end
        @(posedge clk); #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_consumed: got vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        compared++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h10) begin
            mismatched++;
            $display("FAIL b2b_second_accept: got busy=%b rdy=%b sum=%h, want 1 0 10", busy, in_ready, sum);
        end
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        compared++;
        if (n !== 9 || sum !== 8'h00 || carry_out !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_second: got lat=%0d sum=%h c=%b, want 9 00 1", n, sum, carry_out);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int         n;
        logic [7:0] x, y;
        logic [8:0] exp;
        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            exp = {1'b0, x} + {1'b0, y};
            accept(x, y);
            a = ~x; b = ~y;
            wait_valid(1'b1, n);
            compared++;
            if (n !== 9 || sum !== exp[7:0] || carry_out !== exp[8]) begin
                mismatched++;
                $display("FAIL random[%0d] %h+%h: got lat=%0d sum=%h c=%b, want 9 %h %b",
                         i, x, y, n, sum, carry_out, exp[7:0], exp[8]);
            end
            for (int k = 0; k < 20 && out_valid; k++) begin
                @(negedge clk);
                out_ready = (k == 19) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                if (out_valid) begin
                    compared++;
                    if (sum !== exp[7:0] || carry_out !== exp[8]) begin
                        mismatched++;
                        $display("FAIL random_hold[%0d]: got sum=%h c=%b, want %h %b",
                                 i, sum, carry_out, exp[7:0], exp[8]);
                    end
                end
            end
            out_ready = 1'b0;
            compared++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL random_consume[%0d]: got vld=%b rdy=%b, want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_carry();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
